// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared defaults and source-index map for the registered datapath bus
package bus_pkg;

  localparam int BUS_WIDTH      = 32;
  localparam int BUS_N_SRC      = 24;
  localparam int CONFLICT_CNT_W = 8;

  // Source slot map; slot 23 is spare and must be tied off by the integrator
  localparam int SRC_R0     = 0;
  localparam int SRC_R1     = 1;
  localparam int SRC_R2     = 2;
  localparam int SRC_R3     = 3;
  localparam int SRC_R4     = 4;
  localparam int SRC_R5     = 5;
  localparam int SRC_R6     = 6;
  localparam int SRC_R7     = 7;
  localparam int SRC_R8     = 8;
  localparam int SRC_R9     = 9;
  localparam int SRC_R10    = 10;
  localparam int SRC_R11    = 11;
  localparam int SRC_R12    = 12;
  localparam int SRC_R13    = 13;
  localparam int SRC_R14    = 14;
  localparam int SRC_R15    = 15;
  localparam int SRC_HI     = 16;
  localparam int SRC_LO     = 17;
  localparam int SRC_ZHI    = 18;
  localparam int SRC_ZLO    = 19;
  localparam int SRC_PC     = 20;
  localparam int SRC_MDR    = 21;
  localparam int SRC_INPORT = 22;

  localparam logic [CONFLICT_CNT_W-1:0] CONFLICT_CNT_MAX = '1;

endpackage

// File: rtl/onehot_prio_enc.sv
// rtl/onehot_prio_enc.sv - lowest-index priority encoder with any/multi-hot flags
module onehot_prio_enc #(
  parameter  int N_SRC = 24,
  localparam int SEL_W = $clog2(N_SRC)
) (
  input  logic [N_SRC-1:0] en,
  output logic [SEL_W-1:0] index,
  output logic             any,
  output logic             multi
);

  // Scan from the top down so the lowest set index is the last write
  always_comb begin
    index = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (en[i]) index = SEL_W'(i);
    end
  end

  assign any   = |en;
  // Clearing the lowest set bit leaves something only when two or more were set
  assign multi = |(en & (en - N_SRC'(1)));

endmodule

// File: rtl/bus_arbiter_reg.sv
// rtl/bus_arbiter_reg.sv - registered priority bus with conflict detection
// Optional saturating conflict counter enabled by BUS_CONFLICT_CNT_EN.
module bus_arbiter_reg
  import bus_pkg::*;
#(
  parameter  int N_SRC     = BUS_N_SRC,
  parameter  int WIDTH     = BUS_WIDTH,
  parameter  int HOLD_IDLE = 1,
  localparam int SEL_W     = $clog2(N_SRC)
) (
  input  logic                      clock,
  input  logic                      clear,
  input  logic [N_SRC-1:0]          src_out_en,
  input  logic [N_SRC*WIDTH-1:0]    src_data,
  input  logic                      err_clr,
  output logic [WIDTH-1:0]          bus_out,
  output logic                      bus_valid,
  output logic [SEL_W-1:0]          bus_src,
  output logic                      conflict,
  output logic                      conflict_sticky,
  output logic [CONFLICT_CNT_W-1:0] conflict_cnt
);

  logic [SEL_W-1:0] win_idx;
  logic             win_any;
  logic             win_multi;
  logic [WIDTH-1:0] words [N_SRC];

  onehot_prio_enc #(.N_SRC(N_SRC)) u_enc (
    .en    (src_out_en),
    .index (win_idx),
    .any   (win_any),
    .multi (win_multi)
  );

  for (genvar g = 0; g < N_SRC; g++) begin : g_words
    assign words[g] = src_data[g*WIDTH +: WIDTH];
  end

  always_ff @(posedge clock) begin
    if (!clear) begin
      bus_out   <= '0;
      bus_src   <= '0;
      bus_valid <= 1'b0;
      conflict  <= 1'b0;
    end else begin
      bus_valid <= win_any;
      conflict  <= win_multi;
      if (win_any) begin
        bus_out <= words[win_idx];
        bus_src <= win_idx;
      end else if (HOLD_IDLE == 0) begin
        bus_out <= '0;
        bus_src <= '0;
      end
    end
  end

  // A fresh conflict outranks a simultaneous clear so no event is lost
  always_ff @(posedge clock) begin
    if (!clear) begin
      conflict_sticky <= 1'b0;
    end else if (win_multi) begin
      conflict_sticky <= 1'b1;
    end else if (err_clr) begin
      conflict_sticky <= 1'b0;
    end
  end

`ifdef BUS_CONFLICT_CNT_EN
  always_ff @(posedge clock) begin
    if (!clear) begin
      conflict_cnt <= '0;
    end else if (err_clr) begin
      conflict_cnt <= win_multi ? CONFLICT_CNT_W'(1) : '0;
    end else if (win_multi && conflict_cnt != CONFLICT_CNT_MAX) begin
      conflict_cnt <= conflict_cnt + CONFLICT_CNT_W'(1);
    end
  end
`else
  assign conflict_cnt = '0;
`endif

endmodule

// File: tb/tb_bus_arbiter_reg.sv
// tb/tb_bus_arbiter_reg.sv - scoreboard bench for bus_arbiter_reg with a behavioural model
module tb_bus_arbiter_reg;

  localparam int N_SRC     = 24;
  localparam int WIDTH     = 32;
  localparam int HOLD_IDLE = 1;
  localparam int SEL_W     = $clog2(N_SRC);

  logic                   clock = 1'b0;
  logic                   clear = 1'b0;
  logic [N_SRC-1:0]       src_out_en = '0;
  logic [N_SRC*WIDTH-1:0] src_data = '0;
  logic                   err_clr = 1'b0;
  logic [WIDTH-1:0]       bus_out;
  logic                   bus_valid;
  logic [SEL_W-1:0]       bus_src;
  logic                   conflict;
  logic                   conflict_sticky;
  logic [7:0]             conflict_cnt;

  bus_arbiter_reg #(.N_SRC(N_SRC), .WIDTH(WIDTH), .HOLD_IDLE(HOLD_IDLE)) dut (
    .clock           (clock),
    .clear           (clear),
    .src_out_en      (src_out_en),
    .src_data        (src_data),
    .err_clr         (err_clr),
    .bus_out         (bus_out),
    .bus_valid       (bus_valid),
    .bus_src         (bus_src),
    .conflict        (conflict),
    .conflict_sticky (conflict_sticky),
    .conflict_cnt    (conflict_cnt)
  );

  always #5 clock = ~clock;

  typedef struct {
    int               step;
    logic [WIDTH-1:0] out;
    logic [SEL_W-1:0] src;
    logic             valid;
    logic             conf;
    logic             sticky;
    logic [7:0]       cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   step = 0;

  // Reference state
  logic [WIDTH-1:0] m_out = '0;
  int               m_src = 0;
  logic             m_valid = 1'b0;
  logic             m_conf = 1'b0;
  logic             m_sticky = 1'b0;
  int               m_cnt = 0;

  task automatic check(input string name, input int s, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s step=%0d got=%h want=%h", name, s, got, want);
    end
  endtask

  // Apply one cycle of inputs and predict the state after the next edge
  task automatic drive(input logic clr, input logic [N_SRC-1:0] en,
                       input logic [N_SRC*WIDTH-1:0] data, input logic eclr);
    exp_t e;
    int   n;
    int   lo;
    @(negedge clock);
    clear      = clr;
    src_out_en = en;
    src_data   = data;
    err_clr    = eclr;
    n  = $countones(en);
    lo = -1;
    for (int i = 0; i < N_SRC; i++) if (en[i] && lo < 0) lo = i;
    if (!clr) begin
      m_out = '0; m_src = 0; m_valid = 0; m_conf = 0; m_sticky = 0; m_cnt = 0;
    end else begin
      m_valid = (n > 0);
      m_conf  = (n >= 2);
      if (n > 0) begin
        m_out = data[lo*WIDTH +: WIDTH];
        m_src = lo;
      end else if (HOLD_IDLE == 0) begin
        m_out = '0;
        m_src = 0;
      end
      if (n >= 2) m_sticky = 1'b1;
      else if (eclr) m_sticky = 1'b0;
`ifdef BUS_CONFLICT_CNT_EN
      if (eclr) m_cnt = (n >= 2) ? 1 : 0;
      else if (n >= 2) m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
`endif
    end
    step++;
    e.step   = step;
    e.out    = m_out;
    e.src    = SEL_W'(m_src);
    e.valid  = m_valid;
    e.conf   = m_conf;
    e.sticky = m_sticky;
    e.cnt    = 8'(m_cnt);
    exp_q.push_back(e);
  endtask

  // Monitor: the bus is registered, so each edge presents a fresh response
  always @(posedge clock) begin
    exp_t e;
    #2;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("bus_out",         e.step, 64'(bus_out),         64'(e.out));
      check("bus_src",         e.step, 64'(bus_src),         64'(e.src));
      check("bus_valid",       e.step, 64'(bus_valid),       64'(e.valid));
      check("conflict",        e.step, 64'(conflict),        64'(e.conf));
      check("conflict_sticky", e.step, 64'(conflict_sticky), 64'(e.sticky));
      check("conflict_cnt",    e.step, 64'(conflict_cnt),    64'(e.cnt));
    end
  end

  function automatic logic [N_SRC*WIDTH-1:0] rand_data();
    logic [N_SRC*WIDTH-1:0] d;
    for (int i = 0; i < N_SRC; i++) d[i*WIDTH +: WIDTH] = $urandom;
    return d;
  endfunction

  function automatic logic [N_SRC-1:0] rand_en();
    logic [N_SRC-1:0] v;
    v = '0;
    case ($urandom_range(0, 3))
      0: v = '0;
      1: v[$urandom_range(0, N_SRC-1)] = 1'b1;
      2: begin
        v[$urandom_range(0, N_SRC-1)] = 1'b1;
        v[$urandom_range(0, N_SRC-1)] = 1'b1;
      end
      default: v = N_SRC'($urandom);
    endcase
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog step=%0d got=timeout want=finish", step);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N_SRC*WIDTH-1:0] d;
    logic [N_SRC-1:0]       en;

    // Reset dominates an active source
    d = rand_data(); d[3*WIDTH +: WIDTH] = 32'hDEAD_BEEF;
    drive(1'b0, N_SRC'(1) << 3, d, 1'b0);
    drive(1'b0, '0, d, 1'b0);

    // Single source then idle hold
    d = rand_data(); d[5*WIDTH +: WIDTH] = 32'h0000_1234;
    drive(1'b1, N_SRC'(1) << 5, d, 1'b0);
    repeat (3) drive(1'b1, '0, rand_data(), 1'b0);

    // Conflict between slots 2 and 7, sticky survives until err_clr
    d = rand_data();
    d[2*WIDTH +: WIDTH] = 32'hAAAA_0002;
    d[7*WIDTH +: WIDTH] = 32'hBBBB_0007;
    drive(1'b1, (N_SRC'(1) << 2) | (N_SRC'(1) << 7), d, 1'b0);
    drive(1'b1, N_SRC'(1) << 9, rand_data(), 1'b0);
    drive(1'b1, '0, rand_data(), 1'b0);
    drive(1'b1, '0, rand_data(), 1'b1);

    // Priority boundary at both ends of the vector
    drive(1'b1, (N_SRC'(1) << (N_SRC-1)) | N_SRC'(1), rand_data(), 1'b0);
    drive(1'b1, N_SRC'(1) << (N_SRC-1), rand_data(), 1'b1);

    // Long conflict run saturates the counter, then clear with conflict
    repeat (300) drive(1'b1, N_SRC'(3) << $urandom_range(0, N_SRC-2), rand_data(), 1'b0);
    drive(1'b1, (N_SRC'(1) << 4) | (N_SRC'(1) << 11), rand_data(), 1'b1);
    drive(1'b1, '0, rand_data(), 1'b1);

    // Randomized traffic with occasional err_clr and reset
    for (int k = 0; k < 600; k++) begin
      en = rand_en();
      drive(($urandom_range(0, 49) != 0), en, rand_data(), ($urandom_range(0, 9) == 0));
    end

    drive(1'b1, '0, rand_data(), 1'b0);
    @(negedge clock);
    @(negedge clock);
    check("queue_drained", step, 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
